// File: rtl/wb_pkg.sv
// Shared defaults and entry type for the write-back staging queue.
// Holds no logic; widths here are the queue's defaults.
package wb_pkg;
   localparam int WB_DEPTH = 4;
   localparam int WB_DW    = 32;
   localparam int WB_AW    = 5;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

   localparam logic [WB_AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup for one read port: youngest buffered entry matching raddr wins.
// Purely combinational, same-cycle result; no flow control.
module wb_fwd_match
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int DW    = WB_DW,
   parameter int AW    = WB_AW,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][AW-1:0] addr_i,
   input  logic [DEPTH-1:0][DW-1:0] data_i,
   input  logic [DEPTH-1:0]         valid_i,
   input  logic [PW-1:0]            tail_i,
   input  logic [AW-1:0]            raddr_i,
   output logic                     hit_o,
   output logic [DW-1:0]            data_o
);

   logic          found;
   logic [PW-1:0] idx;

   // k=0 is the slot just behind the tail, i.e. the youngest entry
   always_comb begin
      found  = 1'b0;
      idx    = '0;
      data_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = tail_i - PW'(k + 1);
         if (!found && valid_i[idx] && (raddr_i != AW'(REG_ZERO)) && (addr_i[idx] == raddr_i)) begin
            found  = 1'b1;
            data_o = data_i[idx];
         end
      end
      hit_o = found;
   end

endmodule

// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register-file write port, with decode forwarding.
// Enqueue-to-write latency 1 cycle; in_ready drops when full (no pass-through), drains on wr_grant.
module wb_write_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int DW    = WB_DW,
   parameter int AW    = WB_AW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_data,
   input  logic          wr_grant,
   output logic          wr,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] din,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output logic          fwd_hit1,
   output logic          fwd_hit2,
   output logic [DW-1:0] fwd_data1,
   output logic [DW-1:0] fwd_data2,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [PW-1:0]            head_q, head_d;
   logic [PW-1:0]            tail_q, tail_d;
   logic [CW-1:0]            count_q, count_d;
   logic [DEPTH-1:0][AW-1:0] addr_q;
   logic [DEPTH-1:0][DW-1:0] data_q;
   logic [DEPTH-1:0]         valid;
   logic                     enq;
   logic                     store;

   assign in_ready = !rst && (count_q < CW'(DEPTH));
   assign enq      = in_valid && in_ready;
   // writes to r0 complete the handshake but are never buffered
   assign store    = enq && (in_addr != AW'(REG_ZERO));
   assign empty    = (count_q == '0);
   assign wr       = !rst && !empty && wr_grant;
   assign waddr    = empty ? '0 : addr_q[head_q];
   assign din      = empty ? '0 : data_q[head_q];
   assign count    = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(store) - CW'(wr);
      if (store) tail_d = tail_q + PW'(1);
      if (wr)    head_d = head_q + PW'(1);
   end

   // slot i is live when its distance from the head is below the occupancy
   always_comb begin
      valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = ({1'b0, PW'(PW'(i) - head_q)} < count_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         addr_q[tail_q] <= in_addr;
         data_q[tail_q] <= in_data;
      end
   end

   wb_fwd_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fwd1 (
      .addr_i  (addr_q),
      .data_i  (data_q),
      .valid_i (valid),
      .tail_i  (tail_q),
      .raddr_i (raddr1),
      .hit_o   (fwd_hit1),
      .data_o  (fwd_data1)
   );

   wb_fwd_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fwd2 (
      .addr_i  (addr_q),
      .data_i  (data_q),
      .valid_i (valid),
      .tail_i  (tail_q),
      .raddr_i (raddr2),
      .hit_o   (fwd_hit2),
      .data_o  (fwd_data2)
   );

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios plus random traffic against a queue-based model.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_wb_write_queue;
   import wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic          wr_grant = 1'b0;
   logic          wr;
   logic [AW-1:0] waddr;
   logic [DW-1:0] din;
   logic [AW-1:0] raddr1 = '0;
   logic [AW-1:0] raddr2 = '0;
   logic          fwd_hit1, fwd_hit2;
   logic [DW-1:0] fwd_data1, fwd_data2;
   logic [CW-1:0] count;
   logic          empty;

   always #5 clk = ~clk;

   wb_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .wr_grant(wr_grant), .wr(wr), .waddr(waddr), .din(din),
      .raddr1(raddr1), .raddr2(raddr2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .count(count), .empty(empty)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [AW-1:0] mq_addr[$];
   logic [DW-1:0] mq_data[$];
   wb_entry_t     obs_log[$];
   wb_entry_t     wexp[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Youngest match = last element of the model queue with that address
   function automatic void ref_fwd(input logic [AW-1:0] ra, output logic h, output logic [DW-1:0] d);
      h = 1'b0;
      d = '0;
      if (ra != '0) begin
         for (int i = mq_addr.size() - 1; i >= 0; i--) begin
            if (mq_addr[i] == ra) begin
               h = 1'b1;
               d = mq_data[i];
               break;
            end
         end
      end
   endfunction

   task automatic step(input logic r, input logic iv, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                       input logic g, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      int            sz;
      logic          eh;
      logic [DW-1:0] ed;
      bit            acc, pop;
      @(negedge clk);
      rst = r; in_valid = iv; in_addr = ia; in_data = id; wr_grant = g; raddr1 = r1; raddr2 = r2;
      #1;
      sz = mq_addr.size();
      chk("count", 64'(count), 64'(sz));
      chk("empty", 64'(empty), 64'(sz == 0));
      chk("in_ready", 64'(in_ready), 64'(!r && sz < DEPTH));
      chk("wr", 64'(wr), 64'(!r && sz > 0 && g));
      chk("waddr", 64'(waddr), (sz > 0) ? 64'(mq_addr[0]) : 64'(0));
      chk("din", 64'(din), (sz > 0) ? 64'(mq_data[0]) : 64'(0));
      ref_fwd(r1, eh, ed);
      chk("fwd_hit1", 64'(fwd_hit1), 64'(eh));
      chk("fwd_data1", 64'(fwd_data1), 64'(ed));
      ref_fwd(r2, eh, ed);
      chk("fwd_hit2", 64'(fwd_hit2), 64'(eh));
      chk("fwd_data2", 64'(fwd_data2), 64'(ed));
      if (wr) obs_log.push_back('{addr: waddr, data: din});
      if (r) begin
         mq_addr.delete();
         mq_data.delete();
      end else begin
         acc = iv && (sz < DEPTH);
         pop = g && (sz > 0);
         if (pop) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
         end
         if (acc && ia != '0) begin
            mq_addr.push_back(ia);
            mq_data.push_back(id);
         end
      end
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 3, 5);
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_fwd_hit1", 64'(fwd_hit1), 64'(0));

      // basic drain
      step(0, 1, 5'd3, 32'hA5A5A5A5, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("drain_wr", 64'(wr), 64'(1));
      chk("drain_waddr", 64'(waddr), 64'(3));
      chk("drain_din", 64'(din), 64'hA5A5A5A5);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("drain_empty", 64'(empty), 64'(1));

      // fill and stall, then release
      for (int i = 1; i <= 5; i++) step(0, 1, AW'(i), DW'(100 + i), 0, 0, 0);
      chk("fill_count", 64'(count), 64'(4));
      chk("fill_in_ready", 64'(in_ready), 64'(0));
      obs_log.delete();
      step(0, 1, 5'd5, 32'd105, 1, 0, 0);
      chk("fill_stall5", 64'(in_ready), 64'(0));
      step(0, 1, 5'd5, 32'd105, 1, 0, 0);
      chk("fill_accept5", 64'(in_ready), 64'(1));
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0);
      chk("fill_ncommit", 64'(obs_log.size()), 64'(5));
      for (int i = 0; i < 5 && i < obs_log.size(); i++) begin
         chk("fill_order_addr", 64'(obs_log[i].addr), 64'(i + 1));
         chk("fill_order_data", 64'(obs_log[i].data), 64'(101 + i));
      end

      // youngest forward
      step(0, 1, 5'd7, 32'd1, 0, 0, 0);
      step(0, 1, 5'd7, 32'd2, 0, 0, 0);
      step(0, 1, 5'd7, 32'd3, 0, 0, 0);
      step(0, 0, 0, 0, 0, 5'd7, 5'd0);
      chk("young_hit1", 64'(fwd_hit1), 64'(1));
      chk("young_data1", 64'(fwd_data1), 64'(3));
      chk("young_hit2", 64'(fwd_hit2), 64'(0));
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 5'd7, 5'd7);

      // r0 drop
      obs_log.delete();
      step(0, 1, 5'd0, 32'hFFFFFFFF, 1, 0, 0);
      chk("r0_in_ready", 64'(in_ready), 64'(1));
      step(0, 0, 0, 0, 1, 0, 0);
      chk("r0_count", 64'(count), 64'(0));
      chk("r0_wr", 64'(wr), 64'(0));
      step(0, 0, 0, 0, 1, 0, 0);
      chk("r0_nocommit", 64'(obs_log.size()), 64'(0));

      // wrap with simultaneous enqueue/dequeue
      obs_log.delete();
      wexp.delete();
      for (int i = 0; i < 10; i++) begin
         a = AW'($urandom_range(1, 31));
         d = $urandom;
         wexp.push_back('{addr: a, data: d});
         step(0, 1, a, d, 1, a, 0);
         chk("wrap_count_le1", 64'(count <= 1), 64'(1));
      end
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("wrap_ncommit", 64'(obs_log.size()), 64'(10));
      for (int i = 0; i < 10 && i < obs_log.size(); i++) begin
         chk("wrap_order", 64'(obs_log[i]), 64'(wexp[i]));
      end

      // reset mid-operation
      step(0, 1, 5'd9, 32'd90, 0, 0, 0);
      step(0, 1, 5'd10, 32'd100, 0, 0, 0);
      step(0, 1, 5'd11, 32'd110, 0, 0, 0);
      step(1, 0, 0, 0, 1, 5'd9, 5'd10);
      obs_log.delete();
      step(0, 0, 0, 0, 1, 5'd9, 5'd10);
      chk("mrst_count", 64'(count), 64'(0));
      chk("mrst_wr", 64'(wr), 64'(0));
      chk("mrst_hit1", 64'(fwd_hit1), 64'(0));
      chk("mrst_hit2", 64'(fwd_hit2), 64'(0));
      step(0, 1, 5'd4, 32'd9, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("mrst_ncommit", 64'(obs_log.size()), 64'(1));
      if (obs_log.size() > 0) begin
         chk("mrst_first_addr", 64'(obs_log[0].addr), 64'(4));
         chk("mrst_first_data", 64'(obs_log[0].data), 64'(9));
      end

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
              AW'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 6),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
